rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter N, default 32, write-data width in bits.
REQ-002 Clock and reset: clk input 1, rising-edge clock; rst input 1, synchronous, active-high.
REQ-003 Requester 0 (ALU writeback): req0_valid in 1; req0_dest in 5; req0_data in N; req0_ready out 1.
REQ-004 Requester 1 (load/long-latency writeback): req1_valid in 1; req1_dest in 5; req1_data in N; req1_ready out 1.
REQ-005 Issue check from decode: issue_valid in 1; issue_dest in 5; issue_src1 in 5; issue_src2 in 5.
REQ-006 Hazard flag: stall out 1, issue must hold this cycle.
REQ-007 Register-file write port: wr_en out 1, drives RegWrite; wr_dest out 5, drives dest; wr_data out N, drives data.
REQ-008 Scoreboard: busy out 32, bit k set means a write to xk is pending.

Function
REQ-009 Handshake: the block SHALL accept a requester's write in a cycle when its valid and ready are both high; reqX_ready SHALL be combinational from the current grant.
REQ-010 Arbitration: at most one ready SHALL be high per cycle; if exactly one requester is valid, it is granted.
REQ-011 Both valid: the block SHALL grant the requester not granted most recently; last_grant is a 1-bit register updated only on an accepted handshake.
REQ-012 Neither valid: both readies SHALL be 0 and last_grant SHALL hold.
REQ-013 Output stage: wr_en, wr_dest and wr_data SHALL be registered, with 1-cycle latency from handshake to wr_en=1 carrying the accepted dest and data.
REQ-014 When no handshake occurs, wr_en SHALL be 0 next cycle, and wr_dest and wr_data SHALL hold their previous values.
REQ-015 dest=0: the handshake SHALL complete and last_grant SHALL update, but wr_en SHALL stay 0 next cycle (write dropped).
REQ-016 Scoreboard set: when issue_valid=1, stall=0 and issue_dest!=0, busy[issue_dest] SHALL be set at the next edge.
REQ-017 Scoreboard clear: an accepted handshake with dest d!=0 SHALL clear busy[d] at the same edge that wr_en is registered.
REQ-018 Simultaneous set and clear of the same index in one cycle: set SHALL win, so the bit ends at 1.
REQ-019 busy[0] SHALL always read 0.
REQ-020 stall SHALL be combinational and equal issue_valid AND any of the following: (src1!=0 AND busy[src1]), (src2!=0 AND busy[src2]), or (issue_dest!=0 AND busy[issue_dest]).
REQ-021 A stalled issue SHALL NOT modify busy.
REQ-022 stall SHALL use registered busy only; a same-cycle clear SHALL NOT unstall (no bypass).
REQ-023 Requests for a dest whose busy bit is 0 SHALL still be accepted and written; busy is unaffected except by REQ-017.

Reset
REQ-024 While rst=1 at an edge, the block SHALL set busy=0, wr_en=0, wr_dest=0, wr_data=0 and last_grant=1, so requester 0 wins the first contention.
REQ-025 While rst=1, req0_ready, req1_ready and stall SHALL be 0, and no handshake or issue SHALL be recorded.
REQ-026 A reset asserted mid-operation SHALL discard any accepted write not yet presented on wr_en and clear all pending busy bits.

Verification
REQ-027 After reset: req0 and req1 valid with dests 3/4 and data 0xA/0xB. Required: req0 is granted first; next cycle wr_en=1, wr_dest=3, wr_data=0xA; the following cycle wr_dest=4, wr_data=0xB.
REQ-028 Both requesters held valid for 6 cycles. Required: grants strictly alternate 0,1,0,1,0,1.
REQ-029 Issue with dest=5, then issue with src1=5. Required: busy[5]=1 and stall=1; after a req1 write to x5 is accepted, busy[5]=0 one edge later and stall drops that cycle.
REQ-030 req0 with dest=0 and data 0xFFFF. Required: req0_ready=1 but wr_en stays 0; in a following cycle with both valid, req1 is granted.
REQ-031 In one cycle, issue dest=7 while req1 writes x7 (busy[7]=0 beforehand). Required: wr_en=1 with wr_dest=7 next cycle, and busy[7]=1.
REQ-032 Pulse rst with busy=0x0000_0F00 and a write just accepted. Required: next cycle wr_en=0, busy=0, and req0 wins the following contention.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester register-file writeback arbiter with round-robin grant
// and a pending-write scoreboard that stalls issue on RAW/WAW hazards.
module rf_wb_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [4:0]   req0_dest,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [4:0]   req1_dest,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    input  logic         issue_valid,
    input  logic [4:0]   issue_dest,
    input  logic [4:0]   issue_src1,
    input  logic [4:0]   issue_src2,
    output logic         stall,
    output logic         wr_en,
    output logic [4:0]   wr_dest,
    output logic [N-1:0] wr_data,
    output logic [31:0]  busy
);
    logic          last_grant;
    logic          grant0;
    logic          grant1;
    logic          hs;
    logic [4:0]    sel_dest;
    logic [N-1:0]  sel_data;
    logic [31:0]   busy_q;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    // last_grant=1 means requester 1 won last, so requester 0 wins the next contention
    always_comb begin
        grant0   = !rst && req0_valid && (!req1_valid || last_grant);
        grant1   = !rst && req1_valid && (!req0_valid || !last_grant);
        hs       = grant0 || grant1;
        sel_dest = grant0 ? req0_dest : req1_dest;
        sel_data = grant0 ? req0_data : req1_data;
        stall    = !rst && issue_valid &&
                   ((issue_src1 != '0 && busy_q[issue_src1]) ||
                    (issue_src2 != '0 && busy_q[issue_src2]) ||
                    (issue_dest != '0 && busy_q[issue_dest]));
        set_mask = (!rst && issue_valid && !stall && issue_dest != '0) ? 32'd1 << issue_dest : '0;
        clr_mask = (hs && sel_dest != '0) ? 32'd1 << sel_dest : '0;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            wr_en      <= 1'b0;
            wr_dest    <= '0;
            wr_data    <= '0;
            last_grant <= 1'b1;
        end else begin
            busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
            wr_en  <= hs && sel_dest != '0;
            if (hs && sel_dest != '0) begin
                wr_dest <= sel_dest;
                wr_data <= sel_data;
            end
            if (hs)
                last_grant <= grant1;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_dest, req1_dest;
    logic [31:0] req0_data, req1_data;
    logic        issue_valid;
    logic [4:0]  issue_dest, issue_src1, issue_src2;
    logic        stall, wr_en;
    logic [4:0]  wr_dest;
    logic [31:0] wr_data, busy;
    int checks = 0;
    int failures = 0;

    rf_wb_arbiter #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data), .req1_ready(req1_ready),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_src1(issue_src1), .issue_src2(issue_src2),
        .stall(stall), .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_dest = 0; req0_data = 0;
        req1_valid = 0; req1_dest = 0; req1_data = 0;
        issue_valid = 0; issue_dest = 0; issue_src1 = 0; issue_src2 = 0;
        tick();
        tick();
        // reset state and gated outputs while rst is high
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_dest", wr_dest, 0);
        chk("rst_wr_data", wr_data, 0);
        req0_valid = 1; req1_valid = 1; issue_valid = 1; issue_dest = 3;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        tick();
        chk("rst_no_issue", busy, 0);
        chk("rst_no_write", wr_en, 0);
        req0_valid = 0; req1_valid = 0; issue_valid = 0; issue_dest = 0;
        rst = 1'b0;
        tick();

        // first contention: req0 wins, then req1
        req0_valid = 1; req0_dest = 3; req0_data = 32'hA;
        req1_valid = 1; req1_dest = 4; req1_data = 32'hB;
        #1;
        chk("first_ready0", req0_ready, 1);
        chk("first_ready1", req1_ready, 0);
        tick();
        chk("first_wr_en", wr_en, 1);
        chk("first_wr_dest", wr_dest, 3);
        chk("first_wr_data", wr_data, 32'hA);
        req0_valid = 0;
        #1;
        chk("second_ready1", req1_ready, 1);
        tick();
        chk("second_wr_dest", wr_dest, 4);
        chk("second_wr_data", wr_data, 32'hB);
        req1_valid = 0;
        #1;
        chk("idle_ready0", req0_ready, 0);
        chk("idle_ready1", req1_ready, 0);
        tick();
        chk("idle_wr_en", wr_en, 0);
        chk("idle_hold_dest", wr_dest, 4);
        chk("idle_hold_data", wr_data, 32'hB);

        // sustained contention alternates 0,1,0,1,0,1
        req0_valid = 1; req1_valid = 1;
        req0_dest = 1; req1_dest = 2;
        for (int i = 0; i < 6; i++) begin
            req0_data = 32'h100 + i;
            req1_data = 32'h200 + i;
            #1;
            chk("alt_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("alt_ready1", req1_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            chk("alt_wr_data", wr_data, (i % 2 == 0) ? 32'h100 + i : 32'h200 + i);
        end
        req0_valid = 0; req1_valid = 0;
        tick();

        // scoreboard set, stall, no bypass on same-cycle clear
        issue_valid = 1; issue_dest = 5;
        #1;
        chk("sb_issue_nostall", stall, 0);
        tick();
        chk("sb_busy5", busy, 32'h20);
        issue_dest = 6; issue_src1 = 5;
        #1;
        chk("sb_raw_stall", stall, 1);
        tick();
        chk("sb_stalled_nomod", busy, 32'h20);
        req1_valid = 1; req1_dest = 5; req1_data = 32'h55;
        #1;
        chk("sb_no_bypass", stall, 1);
        chk("sb_req1_ready", req1_ready, 1);
        tick();
        chk("sb_cleared", busy, 0);
        chk("sb_wr_dest5", wr_dest, 5);
        chk("sb_unstall", stall, 0);
        req1_valid = 0;
        tick();
        chk("sb_busy6", busy, 32'h40);
        issue_valid = 0; issue_dest = 0; issue_src1 = 0;

        // dest=0 write is dropped but still updates last_grant (req0 won)
        req0_valid = 1; req0_dest = 0; req0_data = 32'hFFFF;
        #1;
        chk("d0_ready0", req0_ready, 1);
        tick();
        chk("d0_wr_en", wr_en, 0);
        req0_dest = 8; req0_data = 32'h8;
        req1_valid = 1; req1_dest = 9; req1_data = 32'h9;
        #1;
        chk("d0_next_ready1", req1_ready, 1);
        chk("d0_next_ready0", req0_ready, 0);
        tick();
        chk("d0_next_dest", wr_dest, 9);
        req0_valid = 0; req1_valid = 0;

        // same-cycle set and clear of x7: set wins
        issue_valid = 1; issue_dest = 7;
        req1_valid = 1; req1_dest = 7; req1_data = 32'h77;
        #1;
        chk("sc_stall", stall, 0);
        chk("sc_ready1", req1_ready, 1);
        tick();
        chk("sc_wr_en", wr_en, 1);
        chk("sc_wr_dest", wr_dest, 7);
        chk("sc_busy", busy, 32'hC0);
        req1_valid = 0;
        issue_dest = 0;
        tick();
        chk("x0_never_busy", busy, 32'hC0);
        issue_valid = 0;

        // drain x6/x7, then build busy = 0xF00
        req0_valid = 1; req0_dest = 6;
        tick();
        req0_dest = 7;
        tick();
        req0_valid = 0;
        chk("drain_busy", busy, 0);
        issue_valid = 1;
        for (int d = 8; d < 12; d++) begin
            issue_dest = 5'(d);
            tick();
        end
        issue_valid = 0; issue_dest = 0;
        chk("pre_rst_busy", busy, 32'hF00);

        // reset in the cycle a write would be accepted
        req1_valid = 1; req1_dest = 8; req1_data = 32'h88;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready1", req1_ready, 0);
        tick();
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        req0_valid = 1; req0_dest = 2; req0_data = 32'h22;
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        tick();
        chk("post_rst_wr_dest", wr_dest, 2);
        req0_valid = 0; req1_valid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
